// File: rtl/tdm_demux.sv
// Receive side of the 4-channel TDM link. Each word is steered into its channel
// slot. A complete frame is presented with a one-cycle strobe, and frame sync is re-acquired after violations.
//
// state  | meaning
// HUNT   | waiting for a sync-marked word to start a frame
// LOCKED | aligned; slot counter tracks the position within the frame
module tdm_demux #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_valid,
    input  logic               in_sync,
    output logic [4*WIDTH-1:0] out_frame,
    output logic               out_valid,
    output logic [1:0]         select_lines,
    output logic               locked,
    output logic               error_demux
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              cnt_q, cnt_d;
    logic [2:0][WIDTH-1:0]   stg_q, stg_d;
    logic [4*WIDTH-1:0]      out_frame_q, out_frame_d;
    logic                    out_valid_q, out_valid_d;
    logic                    error_q, error_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            cnt_q       <= 2'd0;
            stg_q       <= '0;
            out_frame_q <= '0;
            out_valid_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stg_q       <= stg_d;
            out_frame_q <= out_frame_d;
            out_valid_q <= out_valid_d;
            error_q     <= error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stg_d       = stg_q;
        out_frame_d = out_frame_q;
        out_valid_d = 1'b0;
        error_d     = 1'b0;

        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    if (in_sync) begin
                        stg_d[0] = in_data;
                        cnt_d    = 2'd1;
                        state_d  = LOCKED;
                    end
                end
                LOCKED: begin
                    if (in_sync && (cnt_q != 2'd0)) begin
                        // Early sync: the partial frame is abandoned and this word restarts slot 0.
                        error_d  = 1'b1;
                        stg_d[0] = in_data;
                        cnt_d    = 2'd1;
                    end else if (!in_sync && (cnt_q == 2'd0)) begin
                        error_d = 1'b1;
                        cnt_d   = 2'd0;
                        state_d = HUNT;
                    end else begin
                        case (cnt_q)
                            2'd0: begin
                                stg_d[0] = in_data;
                                cnt_d    = 2'd1;
                            end
                            2'd1: begin
                                stg_d[1] = in_data;
                                cnt_d    = 2'd2;
                            end
                            2'd2: begin
                                stg_d[2] = in_data;
                                cnt_d    = 2'd3;
                            end
                            default: begin
                                out_frame_d = {in_data, stg_q[2], stg_q[1], stg_q[0]};
                                out_valid_d = 1'b1;
                                cnt_d       = 2'd0;
                            end
                        endcase
                    end
                end
                default: begin
                    state_d = HUNT;
                    cnt_d   = 2'd0;
                end
            endcase
        end
    end

    assign out_frame    = out_frame_q;
    assign out_valid    = out_valid_q;
    assign select_lines = cnt_q;
    assign locked       = (state_q == LOCKED);
    assign error_demux  = error_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: the expected frames go into a queue when their stimulus is driven.
// A negedge monitor pops the queue and checks each frame as out_valid pulses.
module tb_tdm_demux;

    logic        clk;
    logic        rst_n;
    logic [3:0]  in_data;
    logic        in_valid;
    logic        in_sync;
    logic [15:0] out_frame;
    logic        out_valid;
    logic [1:0]  select_lines;
    logic        locked;
    logic        error_demux;

    int total = 0;
    int bad   = 0;
    int err_seen = 0;
    int frames_seen = 0;
    logic [15:0] exp_q[$];

    tdm_demux #(.WIDTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_sync      (in_sync),
        .out_frame    (out_frame),
        .out_valid    (out_valid),
        .select_lines (select_lines),
        .locked       (locked),
        .error_demux  (error_demux)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every out_valid pulse consumes one expected frame
    always @(negedge clk) begin
        if (rst_n) begin
            if (error_demux) err_seen++;
            if (out_valid) begin
                frames_seen++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_out_valid: out_frame=%h, no frame expected", out_frame);
                end else begin
                    logic [15:0] exp;
                    exp = exp_q.pop_front();
                    if (out_frame !== exp) begin
                        bad++;
                        $display("FAIL frame: got %h expected %h", out_frame, exp);
                    end
                end
                if (error_demux) begin
                    bad++;
                    $display("FAIL exclusive: out_valid and error_demux both 1");
                end
            end
        end
    end

    task automatic send(input logic [3:0] d, input logic s);
        in_data  = d;
        in_sync  = s;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sync  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic check_drained(input string name);
        idle(2);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: %0d frames still pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        in_data = '0; in_valid = 1'b0; in_sync = 1'b0;
        rst_n = 1'b0;
        idle(2);
        total++;
        if ({out_frame, out_valid, select_lines, locked, error_demux} !== 21'd0) begin
            bad++;
            $display("FAIL reset: frame=%h v=%b sel=%0d lock=%b err=%b, expected all 0",
                     out_frame, out_valid, select_lines, locked, error_demux);
        end
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_basic();
        exp_q.push_back(16'h3C5A);
        send(4'hA, 1'b1);
        total++;
        if (locked !== 1'b1 || select_lines !== 2'd1) begin
            bad++;
            $display("FAIL basic_lock: locked=%b sel=%0d, expected 1/1", locked, select_lines);
        end
        send(4'h5, 1'b0);
        send(4'hC, 1'b0);
        send(4'h3, 1'b0);
        total++;
        if (out_valid !== 1'b1 || out_frame !== 16'h3C5A) begin
            bad++;
            $display("FAIL basic_latency: v=%b frame=%h, expected 1/3c5a", out_valid, out_frame);
        end
        idle(1);
        total++;
        if (out_valid !== 1'b0 || out_frame !== 16'h3C5A) begin
            bad++;
            $display("FAIL basic_pulse: v=%b frame=%h, expected 0/3c5a", out_valid, out_frame);
        end
        check_drained("basic");
    endtask

    task automatic test_hunt();
        int e0;
        do_reset();
        e0 = err_seen;
        send(4'h7, 1'b0);
        send(4'h8, 1'b0);
        total++;
        if (locked !== 1'b0 || select_lines !== 2'd0) begin
            bad++;
            $display("FAIL hunt_drop: locked=%b sel=%0d, expected 0/0", locked, select_lines);
        end
        exp_q.push_back(16'h4321);
        send(4'h1, 1'b1); send(4'h2, 1'b0); send(4'h3, 1'b0); send(4'h4, 1'b0);
        check_drained("hunt");
        total++;
        if (err_seen != e0) begin
            bad++;
            $display("FAIL hunt_err: %0d error pulses, expected 0", err_seen - e0);
        end
    endtask

    task automatic test_early_sync();
        int e0;
        e0 = err_seen;
        send(4'h1, 1'b1);
        send(4'h2, 1'b0);
        send(4'h9, 1'b1);
        total++;
        if (error_demux !== 1'b1 || select_lines !== 2'd1 || locked !== 1'b1) begin
            bad++;
            $display("FAIL early_sync: err=%b sel=%0d lock=%b, expected 1/1/1",
                     error_demux, select_lines, locked);
        end
        exp_q.push_back(16'hCBA9);
        send(4'hA, 1'b0); send(4'hB, 1'b0); send(4'hC, 1'b0);
        check_drained("early");
        total++;
        if (err_seen - e0 != 1) begin
            bad++;
            $display("FAIL early_count: %0d error pulses, expected 1", err_seen - e0);
        end
    endtask

    task automatic test_missing_sync();
        exp_q.push_back(16'h0FED);
        send(4'hD, 1'b1); send(4'hE, 1'b0); send(4'hF, 1'b0); send(4'h0, 1'b0);
        send(4'h6, 1'b0);
        total++;
        if (error_demux !== 1'b1 || locked !== 1'b0 || select_lines !== 2'd0
            || out_frame !== 16'h0FED) begin
            bad++;
            $display("FAIL missing_sync: err=%b lock=%b sel=%0d frame=%h, expected 1/0/0/0fed",
                     error_demux, locked, select_lines, out_frame);
        end
        idle(1);
        total++;
        if (error_demux !== 1'b0) begin
            bad++;
            $display("FAIL missing_pulse: err=%b, expected 0", error_demux);
        end
        check_drained("missing");
    endtask

    task automatic test_gaps();
        logic [3:0] w [4];
        logic [1:0] sel_exp [5];
        w = '{4'h1, 4'h2, 4'h3, 4'h4};
        sel_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_q.push_back(16'h4321);
        exp_q.push_back(16'h8765);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (select_lines !== sel_exp[i]) begin
                bad++;
                $display("FAIL gaps_sel%0d: sel=%0d expected %0d", i, select_lines, sel_exp[i]);
            end
            send(w[i], i == 0);
            if (i < 3) idle(2);
        end
        total++;
        if (select_lines !== sel_exp[4] || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL gaps_wrap: sel=%0d v=%b expected 0/1", select_lines, out_valid);
        end
        send(4'h5, 1'b1); send(4'h6, 1'b0); send(4'h7, 1'b0); send(4'h8, 1'b0);
        check_drained("gaps");
    endtask

    task automatic test_back_to_back();
        int f0;
        f0 = frames_seen;
        for (int f = 0; f < 3; f++) begin
            logic [15:0] fr;
            fr = 16'($urandom);
            exp_q.push_back(fr);
            for (int s = 0; s < 4; s++) send(fr[s*4 +: 4], s == 0);
        end
        check_drained("b2b");
        total++;
        if (frames_seen - f0 != 3) begin
            bad++;
            $display("FAIL b2b_count: %0d pulses, expected 3", frames_seen - f0);
        end
    endtask

    task automatic test_reset_mid();
        int e0, f0;
        send(4'h1, 1'b1);
        send(4'h2, 1'b0);
        rst_n = 1'b0;
        #2;
        total++;
        if ({out_frame, out_valid, select_lines, locked, error_demux} !== 21'd0) begin
            bad++;
            $display("FAIL midreset: frame=%h v=%b sel=%0d lock=%b err=%b, expected all 0",
                     out_frame, out_valid, select_lines, locked, error_demux);
        end
        idle(1);
        rst_n = 1'b1;
        e0 = err_seen;
        f0 = frames_seen;
        send(4'h3, 1'b0);
        send(4'h4, 1'b0);
        idle(2);
        total++;
        if (locked !== 1'b0 || err_seen != e0 || frames_seen != f0 || out_frame !== 16'h0) begin
            bad++;
            $display("FAIL midreset_after: lock=%b errs=%0d frames=%0d frame=%h, expected 0/0/0/0000",
                     locked, err_seen - e0, frames_seen - f0, out_frame);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hunt();
        test_early_sync();
        test_missing_sync();
        test_gaps();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
